// File: rtl/bus_pkg.sv
// Shared definitions for the bus master requester: FSM state encoding,
// the default slave-address width and named slave identifiers.
package bus_pkg;

    // Default number of slave-select bits sent serially to the arbiter
    localparam int SLAVE_ADDR_W_DEF = 2;

    // Requester life cycle, one pass per bus transfer
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        SEND     = 3'd2,
        WAIT_GNT = 3'd3,
        OWN      = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Slave identifiers for the default address width
    localparam logic [SLAVE_ADDR_W_DEF-1:0] SLAVE_0 = 2'd0;
    localparam logic [SLAVE_ADDR_W_DEF-1:0] SLAVE_1 = 2'd1;
    localparam logic [SLAVE_ADDR_W_DEF-1:0] SLAVE_2 = 2'd2;
    localparam logic [SLAVE_ADDR_W_DEF-1:0] SLAVE_3 = 2'd3;

endpackage

// File: rtl/bus_master_requester.sv
// Master-side requester for the bus arbiter. Converts a local start command
// into a one-cycle request pulse followed by the slave id sent serially
// MSB first, waits for grant, holds ownership until trans_done and then
// reports completion with a one-cycle done pulse. All outputs registered.
//
// Optional feature: define REQ_TIMEOUT_EN to abandon a request when no grant
// arrives within TIMEOUT_CYCLES cycles (timeout pulse, back to IDLE).
// Without it the requester waits for grant indefinitely and timeout is 0.
module bus_master_requester
    import bus_pkg::*;
#(
    parameter int SLAVE_ADDR_W   = SLAVE_ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    start,
    input  logic [SLAVE_ADDR_W-1:0] slave_id,
    input  logic                    arbiter_busy,
    input  logic                    m_grant,
    input  logic                    trans_done,
    output logic                    m_request,
    output logic                    m_slave_sel,
    output logic                    bus_owned,
    output logic                    ready,
    output logic                    done,
    output logic                    timeout
);

    localparam int CNT_W = (SLAVE_ADDR_W > 1) ? $clog2(SLAVE_ADDR_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLAVE_ADDR_W - 1);

    state_t state_q, state_n;

    logic [SLAVE_ADDR_W-1:0] shift_q, shift_n;
    logic [CNT_W-1:0]        bit_q, bit_n;

    logic req_n, sel_n, own_n, ready_n, done_n, timeout_n;

`ifdef REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wait_q, wait_n;
`endif

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state, next outputs and datapath updates for the requester
    always_comb begin
        state_n   = state_q;
        shift_n   = shift_q;
        bit_n     = bit_q;
        req_n     = 1'b0;
        sel_n     = 1'b0;
        own_n     = 1'b0;
        ready_n   = 1'b0;
        done_n    = 1'b0;
        timeout_n = 1'b0;
`ifdef REQ_TIMEOUT_EN
        wait_n    = wait_q;
`endif
        case (state_q)
            IDLE: begin
                ready_n = 1'b1;
                if (start) begin
                    ready_n = 1'b0;
                    shift_n = slave_id;
                    if (arbiter_busy) begin
                        state_n = HOLD;
                    end else begin
                        state_n = SEND;
                        bit_n   = '0;
                        req_n   = 1'b1;
                        sel_n   = slave_id[SLAVE_ADDR_W-1];
                        shift_n = slave_id << 1;
                    end
                end
            end
            HOLD: begin
                if (!arbiter_busy) begin
                    state_n = SEND;
                    bit_n   = '0;
                    req_n   = 1'b1;
                    sel_n   = shift_q[SLAVE_ADDR_W-1];
                    shift_n = shift_q << 1;
                end
            end
            SEND: begin
                if (bit_q == LAST_BIT) begin
                    state_n = WAIT_GNT;
`ifdef REQ_TIMEOUT_EN
                    wait_n  = '0;
`endif
                end else begin
                    bit_n   = bit_q + CNT_W'(1);
                    sel_n   = shift_q[SLAVE_ADDR_W-1];
                    shift_n = shift_q << 1;
                end
            end
            WAIT_GNT: begin
                if (m_grant) begin
                    state_n = OWN;
                    own_n   = 1'b1;
                end
`ifdef REQ_TIMEOUT_EN
                else if (wait_q == TO_LAST) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                    ready_n   = 1'b1;
                end else begin
                    wait_n = wait_q + TO_W'(1);
                end
`endif
            end
            OWN: begin
                if (trans_done || !m_grant) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    own_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    // Registered outputs, serial shift register and bit counter
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            shift_q     <= '0;
            bit_q       <= '0;
            m_request   <= 1'b0;
            m_slave_sel <= 1'b0;
            bus_owned   <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            shift_q     <= shift_n;
            bit_q       <= bit_n;
            m_request   <= req_n;
            m_slave_sel <= sel_n;
            bus_owned   <= own_n;
            ready       <= ready_n;
            done        <= done_n;
            timeout     <= timeout_n;
        end
    end

`ifdef REQ_TIMEOUT_EN
    // Grant-wait cycle counter, restarted each time WAIT_GNT is entered
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_n;
        end
    end
`endif

endmodule
